// File: rtl/bcd_conv_sched.sv
// Two-requester signed-binary to 5-digit BCD converter with round-robin grant and a double-dabble core.
// Optional macro BCD_FAST_ZERO_EN: an accepted zero operand bypasses conversion and is presented next cycle.
module bcd_conv_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_bcd,
  output logic        out_sign,
  output logic        out_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  logic        rr_r;
  logic        id_r;
  logic        sign_r;
  logic [15:0] mag_r;
  logic [19:0] bcd_r;
  logic [3:0]  cnt_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [19:0] out_bcd_r;
  logic        out_sign_r;
  logic        out_id_r;

  logic        grant_s;
  logic        idle_s;
  logic        accept_s;
  logic [15:0] data_s;
  logic [15:0] mag_in_s;
  logic [19:0] step_s;

  // One double-dabble step: adjust every digit >= 5 by +3, then shift in the next magnitude bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic msb);
    logic [19:0] adj;
    adj = bcd;
    for (int d = 0; d < 5; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = bcd[4*d +: 4];
      end
    end
    return {adj[18:0], msb};
  endfunction

  // Arbitration, handshake readies and operand pre-processing.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = rr_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    idle_s     = rst_n && (state_r == IDLE);
    req0_ready = idle_s && req0_valid && !grant_s;
    req1_ready = idle_s && req1_valid && grant_s;
    accept_s   = req0_ready || req1_ready;
    data_s     = grant_s ? req1_data : req0_data;
    // Negation is taken as unsigned so 0x8000 yields 32768.
    mag_in_s   = data_s[15] ? (~data_s + 16'd1) : data_s;
    step_s     = dabble_step(bcd_r, mag_r[15]);
  end

  // Scheduler FSM, conversion datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      id_r        <= 1'b0;
      sign_r      <= 1'b0;
      mag_r       <= 16'd0;
      bcd_r       <= 20'd0;
      cnt_r       <= 4'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_bcd_r   <= 20'd0;
      out_sign_r  <= 1'b0;
      out_id_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rr_r   <= ~grant_s;
            id_r   <= grant_s;
            sign_r <= data_s[15];
            mag_r  <= mag_in_s;
            bcd_r  <= 20'd0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b1;
`ifdef BCD_FAST_ZERO_EN
            if (data_s == 16'd0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              out_bcd_r   <= 20'd0;
              out_sign_r  <= 1'b0;
              out_id_r    <= grant_s;
            end else begin
              state_r <= CONV;
            end
`else
            state_r <= CONV;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          bcd_r <= step_s;
          mag_r <= {mag_r[14:0], 1'b0};
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            out_bcd_r   <= step_s;
            out_sign_r  <= sign_r;
            out_id_r    <= id_r;
          end else begin
            state_r <= CONV;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_bcd   = out_bcd_r;
  assign out_sign  = out_sign_r;
  assign out_id    = out_id_r;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: latency/arbitration model checked every cycle plus literal directed vectors.
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [19:0] out_bcd;
  logic        out_sign, out_id, busy;

  int checks = 0;
  int failures = 0;

`ifdef BCD_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  bcd_conv_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_sign(out_sign), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = 20'd0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: spec-level arbitration, fixed latency and arithmetic conversion.
  int          cyc = 0;
  logic        m_busy = 1'b0, m_rr = 1'b0, m_zero = 1'b1, m_sign = 1'b0, m_id = 1'b0;
  int          m_due = 0;
  logic [19:0] m_bcd = 20'd0;
  logic        prev_ov = 1'b0;
  int          acc_q[$];
  int          rise_q[$];
  logic [21:0] res_q[$];

  always @(negedge clk) begin
    logic g, er0, er1, ev;
    logic [15:0] d;
    int v;
    g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
    er0 = rst_n && !m_busy && req0_valid && !g;
    er1 = rst_n && !m_busy && req1_valid && g;
    ev  = m_busy && (cyc >= m_due);
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_busy));
    if (ev) begin
      chk("out_bcd", 32'(out_bcd), 32'(m_bcd));
      chk("out_sign", 32'(out_sign), 32'(m_sign));
      chk("out_id", 32'(out_id), 32'(m_id));
    end else if (m_zero) begin
      chk("reset_fields", {11'd0, out_id, out_sign, out_bcd}, 32'd0);
    end
    if (out_valid && !prev_ov) rise_q.push_back(cyc);
    prev_ov = out_valid;
    if (!rst_n) begin
      m_busy = 1'b0; m_rr = 1'b0; m_zero = 1'b1;
    end else if (ev && out_ready) begin
      m_busy = 1'b0;
      res_q.push_back({out_id, out_sign, out_bcd});
    end else if (er0 || er1) begin
      d = g ? req1_data : req0_data;
      v = d[15] ? (65536 - int'(d)) : int'(d);
      m_rr   = ~g;
      m_busy = 1'b1;
      m_zero = 1'b0;
      m_id   = g;
      m_sign = d[15];
      m_bcd  = to_bcd(v);
      m_due  = cyc + ((d == 16'd0) ? ZLAT : 17);
      acc_q.push_back(cyc);
    end
    cyc++;
  end

  task automatic run_one(input string nm, input logic port, input logic [15:0] d,
                         input logic [19:0] eb, input logic es, input int elat);
    bit got;
    acc_q.delete(); res_q.delete(); rise_q.delete();
    out_ready = 1'b1;
    if (port) begin req1_valid = 1'b1; req1_data = d; end
    else begin req0_valid = 1'b1; req0_data = d; end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() > 0) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (res_q.size() > 0) begin got = 1'b1; break; end
    end
    if (!got || rise_q.size() == 0 || acc_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s timeout actual=no_result required=result", nm);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end else begin
      chk({nm, "_bcd"}, 32'(res_q[0][19:0]), 32'(eb));
      chk({nm, "_sign"}, 32'(res_q[0][20]), 32'(es));
      chk({nm, "_id"}, 32'(res_q[0][21]), 32'(port));
      chk({nm, "_latency"}, 32'(rise_q[0] - acc_q[0]), 32'(elat));
    end
  endtask

  initial begin
    int rel;
    bit got;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 16'd0; req1_data = 16'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);

    // Both requesters valid continuously from reset release: strict alternation starting at id 0.
    @(posedge clk); #1;
    acc_q.delete(); res_q.delete(); rise_q.delete();
    req0_valid = 1'b1; req0_data = 16'h0005;
    req1_valid = 1'b1; req1_data = 16'h0009;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel = cyc;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (res_q.size() >= 4) begin got = 1'b1; break; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL rr_order timeout actual=%0d required=4", res_q.size());
    end else begin
      chk("first_accept_after_release", 32'(acc_q[0]), 32'(rel));
      chk("rr0", 32'(res_q[0]), {10'd0, 2'b00, 20'h00005});
      chk("rr1", 32'(res_q[1]), {10'd0, 2'b10, 20'h00009});
      chk("rr2", 32'(res_q[2]), {10'd0, 2'b00, 20'h00005});
      chk("rr3", 32'(res_q[3]), {10'd0, 2'b10, 20'h00009});
    end
    repeat (2) @(posedge clk); #1;

    run_one("p1234", 1'b0, 16'h04D2, 20'h01234, 1'b0, 17);
    run_one("pffff", 1'b1, 16'hFFFF, 20'h00001, 1'b1, 17);
    run_one("p8000", 1'b1, 16'h8000, 20'h32768, 1'b1, 17);
    run_one("p7fff", 1'b0, 16'h7FFF, 20'h32767, 1'b0, 17);
    run_one("pzero", 1'b0, 16'h0000, 20'h00000, 1'b0, ZLAT);

    // Output back-pressure: result held, busy high, no grants while another requester waits.
    acc_q.delete(); res_q.delete(); rise_q.delete();
    out_ready = 1'b0; req1_valid = 1'b1; req1_data = 16'hFFB3;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() > 0) begin
        req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 16'h0123;
        break;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL stall timeout actual=no_valid required=valid");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("stall_bcd", 32'(out_bcd), 32'h00077);
      chk("stall_sign_id", {30'd0, out_id, out_sign}, 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("hs_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a conversion, then a fresh operand.
    @(posedge clk); #1;
    acc_q.delete();
    req0_valid = 1'b1; req0_data = 16'h04D2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() > 0) begin req0_valid = 1'b0; break; end
    end
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fields", {11'd0, out_id, out_sign, out_bcd}, 32'd0);
    chk("midrst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    run_one("p42", 1'b0, 16'd42, 20'h00042, 1'b0, 17);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 SHALL have no parameters; data width fixed at 16-bit signed in, 5-digit BCD (20 bits) plus sign out.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a two's-complement operand.
REQ-005 SHALL have port: req0_data  input  16  requester 0 operand.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 SHALL have port: req1_valid  input  1  requester 1 has a two's-complement operand.
REQ-008 SHALL have port: req1_data  input  16  requester 1 operand.
REQ-009 SHALL have port: req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result.
REQ-012 SHALL have port: out_bcd  output  20  magnitude as 5 BCD digits, MSD in [19:16].
REQ-013 SHALL have port: out_sign  output  1  1 = operand was negative.
REQ-014 SHALL have port: out_id  output  1  index of requester that owns the result.
REQ-015 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CONV, DONE.
REQ-017 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester; at most one ready high per cycle; both ready low outside IDLE.
REQ-018 Grant: only one valid -> that one; both valid -> requester named by round-robin pointer rr; neither -> stay IDLE.
REQ-019 On acceptance rr SHALL be set to the non-granted index; rr unchanged otherwise.
REQ-020 On acceptance: latch id, sign = data[15], magnitude = data[15] ? (~data+1) as 16-bit unsigned : data; clear BCD shift register and set bit counter to 0; go CONV.
REQ-021 Operand 0x8000 SHALL yield magnitude 32768 with sign 1 (unsigned interpretation of the negation).
REQ-022 CONV SHALL perform one double-dabble step per cycle: each of 5 digits >= 5 gets +3, then shift {bcd[18:0], magnitude MSB} and shift magnitude left; 16 steps total, then DONE.
REQ-023 Latency: acceptance in cycle T SHALL give out_valid high in cycle T+17.
REQ-024 In DONE out_valid SHALL be high and out_bcd/out_sign/out_id SHALL be stable until out_valid&&out_ready; then go IDLE.
REQ-025 Next acceptance SHALL occur no earlier than the cycle after the output handshake (no overlap); out_valid low in IDLE and CONV.
REQ-026 Requester data changes while not accepted SHALL have no effect; requester valid dropping before acceptance SHALL be legal.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE, rr=0, out_valid=0, out_bcd=0, out_sign=0, out_id=0, busy=0, both ready=0, from any state including mid-CONV; no partial result is ever presented.
REQ-028 First cycle after reset release SHALL be able to accept.

Configuration
REQ-029 Macro BCD_FAST_ZERO_EN defined: an accepted operand 0x0000 SHALL skip CONV and enter DONE next cycle (out_valid at T+1, out_bcd=0, sign 0).
REQ-030 Macro BCD_FAST_ZERO_EN undefined: zero operand SHALL take the full 17-cycle path like any other value.

Verification
REQ-031 req0 1234 (0x04D2), out_ready=1 -> out_bcd 0x01234, sign 0, id 0, out_valid at T+17.
REQ-032 req1 0xFFFF -> out_bcd 0x00001, sign 1, id 1; req1 0x8000 -> 0x32768 sign 1; req0 0x7FFF -> 0x32767 sign 0.
REQ-033 Both valid every cycle after reset, 0x0005 on req0 and 0x0009 on req1 -> results in order id0 0x00005, id1 0x00009, id0, id1 (strict alternation).
REQ-034 out_ready low 5 cycles after out_valid -> outputs stable, busy high, both ready low; handshake then IDLE next cycle.
REQ-035 rst_n low for 1 cycle at step 8 of CONV -> all outputs reset values next cycle; new operand 42 after release -> 0x00042.
REQ-036 Operand 0 with and without BCD_FAST_ZERO_EN -> out_bcd 0x00000, out_valid at T+1 and T+17 respectively.
